// File: rtl/sonar_checker_pkg.sv
// rtl/sonar_checker_pkg.sv - shared types and LFSR helper for the sonar stream checker
package sonar_checker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;
  typedef enum logic [1:0] {BP_ALWAYS, BP_RANDOM, BP_HOLD, BP_RSVD} bp_mode_t;

  // Right-shifting Fibonacci form: mask bits 0,2,3,5 are the taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {fb, cur[15:1]};
  endfunction

endpackage

// File: rtl/sonar_sync_fifo.sv
// rtl/sonar_sync_fifo.sv - first-word fall-through FIFO with registered flags and sync clear
module sonar_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic [AW:0]      countNext;
  logic             doPush;
  logic             doPop;

  assign doPop     = pop && !empty;
  // A pop frees the slot in the same cycle, so push-while-full is accepted when paired with a pop.
  assign doPush    = push && (!full || doPop);
  assign countNext = count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
  assign dout      = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      full  <= (countNext == DEPTH_V);
      empty <= (countNext == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/sonar_axis_checker.sv
// rtl/sonar_axis_checker.sv - in-order stream scoreboard with backpressure, sticky error flags and idle timeout
module sonar_axis_checker
  import sonar_checker_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int          EXP_DEPTH   = 16,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                eov_req,
  input  logic [1:0]          bp_mode,
  input  logic                exp_valid,
  output logic                exp_ready,
  input  logic [DATA_W-1:0]   exp_data,
  input  logic [DATA_W/8-1:0] exp_keep,
  input  logic                exp_last,
  input  logic                mon_tvalid,
  output logic                mon_tready,
  input  logic [DATA_W-1:0]   mon_tdata,
  input  logic [DATA_W/8-1:0] mon_tkeep,
  input  logic                mon_tlast,
  output logic [31:0]         beat_cnt,
  output logic [15:0]         err_cnt,
  output logic [31:0]         first_err_idx,
  output logic                err_mismatch,
  output logic                err_unexpect,
  output logic                err_timeout,
  output logic                done
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int FW     = DATA_W + KEEP_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC);

  chk_state_t         state;
  logic [15:0]        lfsr;
  logic               active;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [FW-1:0]      headWord;
  logic [DATA_W-1:0]  headData;
  logic [KEEP_W-1:0]  headKeep;
  logic               headLast;
  logic               accept;
  logic               dataDiff;
  logic               isMismatch;
  logic               isUnexpect;
  logic               anyErr;
  logic [IDLE_W-1:0]  idleCnt;
  logic [IDLE_W-1:0]  idleNext;
  logic               timeoutHit;

  assign active    = (state == RUN) || (state == DRAIN);
  assign exp_ready = active && !fifoFull;

  always_comb begin
    mon_tready = 1'b0;
    if (active) begin
      case (bp_mode_t'(bp_mode))
        BP_RANDOM: mon_tready = lfsr[0];
        BP_HOLD:   mon_tready = 1'b0;
        default:   mon_tready = 1'b1;
      endcase
    end
  end

  assign accept = mon_tvalid && mon_tready;

  sonar_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (EXP_DEPTH)
  ) u_exp_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .push  (exp_valid && exp_ready),
    .din   ({exp_data, exp_keep, exp_last}),
    .pop   (accept && !fifoEmpty),
    .dout  (headWord),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign {headData, headKeep, headLast} = headWord;

  // Bytes the expectation marks as not kept are don't-care for data.
  always_comb begin
    dataDiff = 1'b0;
    for (int b = 0; b < KEEP_W; b++) begin
      if (headKeep[b] && (headData[8*b +: 8] != mon_tdata[8*b +: 8])) dataDiff = 1'b1;
    end
  end

  assign isMismatch = accept && !fifoEmpty &&
                      (dataDiff || (headKeep != mon_tkeep) || (headLast != mon_tlast));
  assign isUnexpect = accept && fifoEmpty;
  assign anyErr     = isMismatch || isUnexpect;

  assign idleNext   = idleCnt + 1'b1;
  assign timeoutHit = active && !fifoEmpty && !accept && (idleNext == IDLE_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsrNext(lfsr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      beat_cnt      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      err_mismatch  <= 1'b0;
      err_unexpect  <= 1'b0;
      err_timeout   <= 1'b0;
      idleCnt       <= '0;
    end else if (start) begin
      state         <= RUN;
      done          <= 1'b0;
      beat_cnt      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      err_mismatch  <= 1'b0;
      err_unexpect  <= 1'b0;
      err_timeout   <= 1'b0;
      idleCnt       <= '0;
    end else begin
      case (state)
        RUN: begin
          if (timeoutHit) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (eov_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (timeoutHit || fifoEmpty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (timeoutHit) err_timeout  <= 1'b1;
      if (isMismatch) err_mismatch <= 1'b1;
      if (isUnexpect) err_unexpect <= 1'b1;
      if (accept)     beat_cnt     <= beat_cnt + 32'd1;

      // err_cnt only leaves zero through an error, so zero marks "no error latched yet".
      if (anyErr) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'd0)    first_err_idx <= beat_cnt;
      end

      if (!active || accept || fifoEmpty) idleCnt <= '0;
      else                                idleCnt <= idleNext;
    end
  end

endmodule

// File: tb/tb_sonar_axis_checker.sv
// tb/tb_sonar_axis_checker.sv - directed self-checking bench for sonar_axis_checker
module tb_sonar_axis_checker;

  localparam int          DATA_W      = 64;
  localparam int          KEEP_W      = DATA_W / 8;
  localparam int          EXP_DEPTH   = 16;
  localparam int          TIMEOUT_CYC = 32;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  logic              SONAR_VECTOR_CLOCK = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              eov_req = 1'b0;
  logic [1:0]        bp_mode = 2'd0;
  logic              exp_valid = 1'b0;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data = '0;
  logic [KEEP_W-1:0] exp_keep = '0;
  logic              exp_last = 1'b0;
  logic              mon_tvalid = 1'b0;
  logic              mon_tready;
  logic [DATA_W-1:0] mon_tdata = '0;
  logic [KEEP_W-1:0] mon_tkeep = '0;
  logic              mon_tlast = 1'b0;
  logic [31:0]       beat_cnt;
  logic [15:0]       err_cnt;
  logic [31:0]       first_err_idx;
  logic              err_mismatch;
  logic              err_unexpect;
  logic              err_timeout;
  logic              done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] lfsrModel;

  sonar_axis_checker #(
    .DATA_W      (DATA_W),
    .EXP_DEPTH   (EXP_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LFSR_SEED   (LFSR_SEED)
  ) dut (
    .clk           (SONAR_VECTOR_CLOCK),
    .rst           (rst),
    .start         (start),
    .eov_req       (eov_req),
    .bp_mode       (bp_mode),
    .exp_valid     (exp_valid),
    .exp_ready     (exp_ready),
    .exp_data      (exp_data),
    .exp_keep      (exp_keep),
    .exp_last      (exp_last),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tdata     (mon_tdata),
    .mon_tkeep     (mon_tkeep),
    .mon_tlast     (mon_tlast),
    .beat_cnt      (beat_cnt),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .err_mismatch  (err_mismatch),
    .err_unexpect  (err_unexpect),
    .err_timeout   (err_timeout),
    .done          (done)
  );

  always #5 SONAR_VECTOR_CLOCK = ~SONAR_VECTOR_CLOCK;

  // Reference backpressure sequence: x^16+x^14+x^13+x^11, shifted right, new bit into [15].
  always @(posedge SONAR_VECTOR_CLOCK or posedge rst) begin
    if (rst) lfsrModel <= LFSR_SEED;
    else     lfsrModel <= {lfsrModel[0] ^ lfsrModel[2] ^ lfsrModel[3] ^ lfsrModel[5], lfsrModel[15:1]};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge SONAR_VECTOR_CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseEov();
    eov_req = 1'b1;
    tick();
    eov_req = 1'b0;
  endtask

  task automatic pushExp(input logic [63:0] d, input logic [7:0] k, input logic l);
    exp_valid = 1'b1;
    exp_data  = d;
    exp_keep  = k;
    exp_last  = l;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic sendMon(input logic [63:0] d, input logic [7:0] k, input logic l);
    mon_tvalid = 1'b1;
    mon_tdata  = d;
    mon_tkeep  = k;
    mon_tlast  = l;
    tick();
    mon_tvalid = 1'b0;
  endtask

  function automatic logic [63:0] streamBeat(input int i);
    return 64'hA5C3_0000_0000_0000 | 64'(i * 16'h0101);
  endfunction

  initial begin
    logic [63:0] beats [4];
    int pushIdx;
    int monIdx;
    int lfsrBad;
    int sawLow;
    int sawHigh;
    logic pushed;
    logic took;

    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;

    repeat (3) tick();
    check("rst_exp_ready", 64'(exp_ready), 64'd0);
    check("rst_mon_tready", 64'(mon_tready), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_first_err", 64'(first_err_idx), 64'hFFFF_FFFF);
    check("rst_flags", 64'({err_mismatch, err_unexpect, err_timeout, done}), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_exp_ready", 64'(exp_ready), 64'd0);

    // 1: clean four-beat vector, always ready
    bp_mode = 2'd0;
    pulseStart();
    check("t1_run_exp_ready", 64'(exp_ready), 64'd1);
    for (int i = 0; i < 4; i++) pushExp(beats[i], 8'hFF, i == 3);
    for (int i = 0; i < 4; i++) sendMon(beats[i], 8'hFF, i == 3);
    pulseEov();
    tick();
    check("t1_done", 64'(done), 64'd1);
    check("t1_beat_cnt", 64'(beat_cnt), 64'd4);
    check("t1_err_cnt", 64'(err_cnt), 64'd0);
    check("t1_first_err", 64'(first_err_idx), 64'hFFFF_FFFF);
    check("t1_done_exp_ready", 64'(exp_ready), 64'd0);
    check("t1_done_mon_tready", 64'(mon_tready), 64'd0);

    // 2a: byte0 differs but is masked by keep
    pulseStart();
    check("t2_restart_done", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) pushExp(beats[i], (i == 1) ? 8'hFE : 8'hFF, i == 3);
    for (int i = 0; i < 4; i++)
      sendMon((i == 1) ? (beats[i] ^ 64'h0F) : beats[i], (i == 1) ? 8'hFE : 8'hFF, i == 3);
    check("t2a_err_cnt", 64'(err_cnt), 64'd0);
    check("t2a_mismatch", 64'(err_mismatch), 64'd0);
    check("t2a_beat_cnt", 64'(beat_cnt), 64'd4);

    // 2b: same byte difference with it kept
    pulseStart();
    for (int i = 0; i < 4; i++) pushExp(beats[i], 8'hFF, i == 3);
    for (int i = 0; i < 4; i++)
      sendMon((i == 1) ? (beats[i] ^ 64'h0F) : beats[i], 8'hFF, i == 3);
    check("t2b_mismatch", 64'(err_mismatch), 64'd1);
    check("t2b_err_cnt", 64'(err_cnt), 64'd1);
    check("t2b_first_err", 64'(first_err_idx), 64'd1);
    check("t2b_unexpect", 64'(err_unexpect), 64'd0);

    // 3: beat arrives with nothing expected
    pulseStart();
    sendMon(64'hDEAD_BEEF, 8'hFF, 1'b1);
    check("t3_unexpect", 64'(err_unexpect), 64'd1);
    check("t3_err_cnt", 64'(err_cnt), 64'd1);
    check("t3_first_err", 64'(first_err_idx), 64'd0);
    check("t3_beat_cnt", 64'(beat_cnt), 64'd1);
    check("t3_mismatch", 64'(err_mismatch), 64'd0);
    pulseEov();
    tick();
    check("t3_drained_empty", 64'(done), 64'd1);

    // 4: forced timeout with ready held low
    bp_mode = 2'd2;
    pulseStart();
    pushExp(64'h5555, 8'hFF, 1'b1);
    check("t4_hold_tready", 64'(mon_tready), 64'd0);
    mon_tvalid = 1'b1;
    mon_tdata  = 64'h5555;
    mon_tkeep  = 8'hFF;
    mon_tlast  = 1'b1;
    repeat (TIMEOUT_CYC - 1) tick();
    check("t4_no_timeout_yet", 64'(err_timeout), 64'd0);
    check("t4_not_done_yet", 64'(done), 64'd0);
    tick();
    mon_tvalid = 1'b0;
    check("t4_timeout", 64'(err_timeout), 64'd1);
    check("t4_done", 64'(done), 64'd1);
    check("t4_mon_tready", 64'(mon_tready), 64'd0);
    check("t4_beat_cnt", 64'(beat_cnt), 64'd0);

    // 5: LFSR backpressure, fill past depth against a streaming DUT
    bp_mode = 2'd1;
    pulseStart();
    for (int i = 0; i < EXP_DEPTH; i++) pushExp(streamBeat(i), 8'hFF, (i % 4) == 3);
    check("t5_full_exp_ready", 64'(exp_ready), 64'd0);
    pushIdx = EXP_DEPTH;
    monIdx  = 0;
    lfsrBad = 0;
    sawLow  = 0;
    sawHigh = 0;
    for (int cyc = 0; cyc < 400 && monIdx < EXP_DEPTH + 4; cyc++) begin
      exp_valid  = (pushIdx < EXP_DEPTH + 4);
      exp_data   = streamBeat(pushIdx);
      exp_keep   = 8'hFF;
      exp_last   = (pushIdx % 4) == 3;
      mon_tvalid = 1'b1;
      mon_tdata  = streamBeat(monIdx);
      mon_tkeep  = 8'hFF;
      mon_tlast  = (monIdx % 4) == 3;
      if (mon_tready !== lfsrModel[0]) lfsrBad++;
      if (mon_tready === 1'b1) sawHigh++;
      else                     sawLow++;
      pushed = exp_valid && exp_ready;
      took   = mon_tready;
      tick();
      if (pushed) pushIdx++;
      if (took)   monIdx++;
    end
    exp_valid  = 1'b0;
    mon_tvalid = 1'b0;
    check("t5_tready_vs_lfsr", 64'(lfsrBad), 64'd0);
    check("t5_tready_toggles", 64'((sawLow > 0) && (sawHigh > 0)), 64'd1);
    check("t5_all_pushed", 64'(pushIdx), 64'(EXP_DEPTH + 4));
    check("t5_all_sent", 64'(monIdx), 64'(EXP_DEPTH + 4));
    check("t5_beat_cnt", 64'(beat_cnt), 64'(EXP_DEPTH + 4));
    check("t5_err_cnt", 64'(err_cnt), 64'd0);
    check("t5_flags", 64'({err_mismatch, err_unexpect, err_timeout}), 64'd0);

    // 6: asynchronous reset while draining with beats queued
    bp_mode = 2'd0;
    pulseStart();
    sendMon(64'h0BAD, 8'hFF, 1'b1);
    bp_mode = 2'd2;
    for (int i = 0; i < 3; i++) pushExp(beats[i], 8'hFF, i == 2);
    pulseEov();
    check("t6_draining", 64'(done), 64'd0);
    check("t6_pre_rst_beat_cnt", 64'(beat_cnt), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_exp_ready", 64'(exp_ready), 64'd0);
    check("t6_rst_mon_tready", 64'(mon_tready), 64'd0);
    check("t6_rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("t6_rst_first_err", 64'(first_err_idx), 64'hFFFF_FFFF);
    check("t6_rst_flags", 64'({err_mismatch, err_unexpect, err_timeout, done}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle_exp_ready", 64'(exp_ready), 64'd0);
    bp_mode = 2'd0;
    pulseStart();
    pushExp(64'h7777_0000_7777_0000, 8'hFF, 1'b1);
    sendMon(64'h7777_0000_7777_0000, 8'hFF, 1'b1);
    pulseEov();
    tick();
    check("t6_clean_done", 64'(done), 64'd1);
    check("t6_clean_beat_cnt", 64'(beat_cnt), 64'd1);
    check("t6_clean_err_cnt", 64'(err_cnt), 64'd0);
    check("t6_clean_flags", 64'({err_mismatch, err_unexpect, err_timeout}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
